// File: rtl/mvau_out_dwc.sv
// Receives packed PE-lane result words, buffers them in a small FIFO and
// serialises them into a one-element-per-beat valid/ready stream with per-pixel last marking.
module mvau_out_dwc #(
   parameter int PE         = 2,
   parameter int TDstI      = 16,
   parameter int MatrixH    = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_v,
   input  logic [PE*TDstI-1:0]   in_data,
   output logic                  out_v,
   input  logic                  out_rdy,
   output logic [TDstI-1:0]      out_data,
   output logic                  out_last,
   output logic                  ovf
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int LW = (PE > 1) ? $clog2(PE) : 1;
   localparam int HW = (MatrixH > 1) ? $clog2(MatrixH) : 1;

   localparam logic [CW-1:0] C_FULL      = CW'(FIFO_DEPTH);
   localparam logic [LW-1:0] C_LANE_LAST = LW'(PE - 1);
   localparam logic [HW-1:0] C_CH_LAST   = HW'(MatrixH - 1);

   logic [PE*TDstI-1:0] r_mem [FIFO_DEPTH];
   logic [AW-1:0]       r_wr_ptr;
   logic [AW-1:0]       r_rd_ptr;
   logic [CW-1:0]       r_count;
   logic [LW-1:0]       r_lane;
   logic [HW-1:0]       r_ch;
   logic                r_ovf;

   logic                w_out_v;
   logic                w_beat;
   logic                w_pop;
   logic                w_full;
   logic                w_wr;
   logic                w_drop;
   logic [PE*TDstI-1:0] w_head;
   logic [TDstI-1:0]    w_elem;

   assign w_out_v = (r_count != '0);
   assign w_full  = (r_count == C_FULL);
   assign w_beat  = w_out_v && out_rdy;
   assign w_pop   = w_beat && (r_lane == C_LANE_LAST);
   // A pop in the same cycle frees the slot, so a write at full is still accepted.
   assign w_wr    = in_v && (!w_full || w_pop);
   assign w_drop  = in_v && w_full && !w_pop;

   // Storage needs no reset: occupancy gates every read.
   always_ff @(posedge clk) begin
      if (w_wr) begin
         r_mem[r_wr_ptr] <= in_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_wr) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         case ({w_wr, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_lane <= '0;
         r_ch   <= '0;
      end else if (w_beat) begin
         if (r_lane == C_LANE_LAST) begin
            r_lane <= '0;
         end else begin
            r_lane <= r_lane + LW'(1);
         end
         if (r_ch == C_CH_LAST) begin
            r_ch <= '0;
         end else begin
            r_ch <= r_ch + HW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ovf <= 1'b0;
      end else if (w_drop) begin
         r_ovf <= 1'b1;
      end
   end

   // Lane 0 occupies the most significant slice of the packed word.
   always_comb begin
      w_head = r_mem[r_rd_ptr];
      w_elem = '0;
      for (int k = 0; k < PE; k++) begin
         if (r_lane == LW'(k)) begin
            w_elem = w_head[(PE-1-k)*TDstI +: TDstI];
         end
      end
   end

   assign out_v    = w_out_v;
   assign out_data = w_out_v ? w_elem : '0;
   assign out_last = w_out_v && (r_ch == C_CH_LAST);
   assign ovf      = r_ovf;

endmodule

// File: tb/tb_mvau_out_dwc.sv
// Directed bench for mvau_out_dwc with PE=2, TDstI=16, MatrixH=16, FIFO_DEPTH=4.
module tb_mvau_out_dwc;

   logic        clk;
   logic        rst_n;
   logic        in_v;
   logic [31:0] in_data;
   logic        out_v;
   logic        out_rdy;
   logic [15:0] out_data;
   logic        out_last;
   logic        ovf;

   int errs;
   int checks;

   mvau_out_dwc #(
      .PE(2), .TDstI(16), .MatrixH(16), .FIFO_DEPTH(4)
   ) dut (
      .clk(clk), .rst_n(rst_n), .in_v(in_v), .in_data(in_data),
      .out_v(out_v), .out_rdy(out_rdy), .out_data(out_data),
      .out_last(out_last), .ovf(ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL timeout: simulation still running at %0t", $time);
      $fatal(1, "timeout");
   end

   task automatic do_reset();
      in_v    = 1'b0;
      in_data = '0;
      out_rdy = 1'b0;
      rst_n   = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (out_v !== 1'b0) begin errs++; $display("FAIL reset_out_v: got %b exp 0", out_v); end
      checks++; if (out_data !== 16'h0000) begin errs++; $display("FAIL reset_out_data: got %h exp 0000", out_data); end
      checks++; if (out_last !== 1'b0) begin errs++; $display("FAIL reset_out_last: got %b exp 0", out_last); end
      checks++; if (ovf !== 1'b0) begin errs++; $display("FAIL reset_ovf: got %b exp 0", ovf); end
   endtask

   task automatic test_single_word();
      do_reset();
      out_rdy = 1'b1;
      in_v    = 1'b1;
      in_data = 32'hAAAA_5555;
      @(negedge clk);
      in_v = 1'b0;
      checks++; if (out_v !== 1'b1) begin errs++; $display("FAIL single_v0: got %b exp 1", out_v); end
      checks++; if (out_data !== 16'hAAAA) begin errs++; $display("FAIL single_d0: got %h exp AAAA", out_data); end
      checks++; if (out_last !== 1'b0) begin errs++; $display("FAIL single_l0: got %b exp 0", out_last); end
      @(negedge clk);
      checks++; if (out_v !== 1'b1) begin errs++; $display("FAIL single_v1: got %b exp 1", out_v); end
      checks++; if (out_data !== 16'h5555) begin errs++; $display("FAIL single_d1: got %h exp 5555", out_data); end
      checks++; if (out_last !== 1'b0) begin errs++; $display("FAIL single_l1: got %b exp 0", out_last); end
      @(negedge clk);
      checks++; if (out_v !== 1'b0) begin errs++; $display("FAIL single_v_end: got %b exp 0", out_v); end
      checks++; if (out_data !== 16'h0000) begin errs++; $display("FAIL single_d_end: got %h exp 0000", out_data); end
   endtask

   task automatic test_pixel_framing();
      int n;
      logic [15:0] exp_d;
      logic exp_l;
      do_reset();
      out_rdy = 1'b1;
      n = 0;
      for (int cyc = 0; cyc < 46; cyc++) begin
         if ((cyc % 2 == 0) && (cyc / 2 < 9)) begin
            in_v    = 1'b1;
            in_data = {16'(16'h1000 + cyc), 16'(16'h1000 + cyc + 1)};
         end else begin
            in_v = 1'b0;
         end
         if (out_v === 1'b1) begin
            exp_d = 16'(16'h1000 + n);
            exp_l = ((n % 16) == 15);
            checks++; if (out_data !== exp_d) begin errs++; $display("FAIL pixel_data[%0d]: got %h exp %h", n, out_data, exp_d); end
            checks++; if (out_last !== exp_l) begin errs++; $display("FAIL pixel_last[%0d]: got %b exp %b", n, out_last, exp_l); end
            n++;
         end
         @(negedge clk);
      end
      in_v = 1'b0;
      checks++; if (n != 18) begin errs++; $display("FAIL pixel_count: got %0d exp 18", n); end
   endtask

   task automatic test_backpressure();
      int n;
      logic [15:0] exp_d;
      do_reset();
      for (int j = 0; j < 3; j++) begin
         in_v    = 1'b1;
         in_data = {16'(16'hC000 + 2*j), 16'(16'hC000 + 2*j + 1)};
         @(negedge clk);
      end
      in_v = 1'b0;
      for (int s = 0; s < 10; s++) begin
         checks++; if (out_v !== 1'b1 || out_data !== 16'hC000 || out_last !== 1'b0) begin
            errs++; $display("FAIL stall[%0d]: got v=%b d=%h l=%b exp v=1 d=C000 l=0", s, out_v, out_data, out_last);
         end
         @(negedge clk);
      end
      out_rdy = 1'b1;
      n = 0;
      for (int cyc = 0; cyc < 20; cyc++) begin
         if (out_v === 1'b1) begin
            exp_d = 16'(16'hC000 + n);
            checks++; if (out_data !== exp_d) begin errs++; $display("FAIL bp_data[%0d]: got %h exp %h", n, out_data, exp_d); end
            n++;
         end
         @(negedge clk);
      end
      checks++; if (n != 6) begin errs++; $display("FAIL bp_count: got %0d exp 6", n); end
      checks++; if (ovf !== 1'b0) begin errs++; $display("FAIL bp_ovf: got %b exp 0", ovf); end
   endtask

   task automatic test_overflow();
      int n;
      logic [15:0] exp_d;
      do_reset();
      for (int j = 0; j < 5; j++) begin
         in_v    = 1'b1;
         in_data = {16'(16'hD000 + 2*j), 16'(16'hD000 + 2*j + 1)};
         @(negedge clk);
         if (j == 3) begin
            checks++; if (ovf !== 1'b0) begin errs++; $display("FAIL ovf_early: got %b exp 0", ovf); end
         end
      end
      in_v = 1'b0;
      checks++; if (ovf !== 1'b1) begin errs++; $display("FAIL ovf_rise: got %b exp 1", ovf); end
      out_rdy = 1'b1;
      n = 0;
      for (int cyc = 0; cyc < 20; cyc++) begin
         if (out_v === 1'b1) begin
            exp_d = 16'(16'hD000 + n);
            checks++; if (out_data !== exp_d) begin errs++; $display("FAIL ovf_data[%0d]: got %h exp %h", n, out_data, exp_d); end
            n++;
         end
         @(negedge clk);
      end
      checks++; if (n != 8) begin errs++; $display("FAIL ovf_count: got %0d exp 8", n); end
      checks++; if (ovf !== 1'b1) begin errs++; $display("FAIL ovf_sticky: got %b exp 1", ovf); end
      rst_n = 1'b0;
      #2;
      checks++; if (ovf !== 1'b0) begin errs++; $display("FAIL ovf_clear: got %b exp 0", ovf); end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_full_pop();
      int n;
      logic [15:0] exp_seq [8];
      exp_seq = '{16'hE002, 16'hE003, 16'hE004, 16'hE005, 16'hE006, 16'hE007, 16'hF000, 16'hF001};
      do_reset();
      for (int j = 0; j < 4; j++) begin
         in_v    = 1'b1;
         in_data = {16'(16'hE000 + 2*j), 16'(16'hE000 + 2*j + 1)};
         @(negedge clk);
      end
      in_v = 1'b0;
      checks++; if (ovf !== 1'b0) begin errs++; $display("FAIL full_ovf_pre: got %b exp 0", ovf); end
      out_rdy = 1'b1;
      @(negedge clk);
      checks++; if (out_data !== 16'hE001) begin errs++; $display("FAIL full_lane1: got %h exp E001", out_data); end
      in_v    = 1'b1;
      in_data = {16'hF000, 16'hF001};
      @(negedge clk);
      in_v    = 1'b0;
      out_rdy = 1'b0;
      checks++; if (ovf !== 1'b0) begin errs++; $display("FAIL full_pop_ovf: got %b exp 0", ovf); end
      checks++; if (out_data !== 16'hE002) begin errs++; $display("FAIL full_head: got %h exp E002", out_data); end
      // One more word with no pop must be dropped if occupancy stayed at four.
      in_v    = 1'b1;
      in_data = {16'h9999, 16'h9999};
      @(negedge clk);
      in_v = 1'b0;
      checks++; if (ovf !== 1'b1) begin errs++; $display("FAIL full_count_kept: got ovf %b exp 1", ovf); end
      out_rdy = 1'b1;
      n = 0;
      for (int cyc = 0; cyc < 20; cyc++) begin
         if (out_v === 1'b1) begin
            if (n < 8) begin
               checks++; if (out_data !== exp_seq[n]) begin errs++; $display("FAIL full_data[%0d]: got %h exp %h", n, out_data, exp_seq[n]); end
            end
            n++;
         end
         @(negedge clk);
      end
      checks++; if (n != 8) begin errs++; $display("FAIL full_drain_count: got %0d exp 8", n); end
   endtask

   task automatic test_reset_mid();
      int n;
      logic [15:0] exp_seq [16];
      logic exp_l;
      exp_seq[0] = 16'h1234;
      exp_seq[1] = 16'h5678;
      for (int i = 2; i < 16; i++) exp_seq[i] = 16'(16'h2000 + i);
      do_reset();
      for (int j = 0; j < 2; j++) begin
         in_v    = 1'b1;
         in_data = {16'(16'hA100 + 2*j), 16'(16'hA100 + 2*j + 1)};
         @(negedge clk);
      end
      in_v    = 1'b0;
      out_rdy = 1'b1;
      @(negedge clk);
      out_rdy = 1'b0;
      checks++; if (out_data !== 16'hA101) begin errs++; $display("FAIL rmid_pre_lane1: got %h exp A101", out_data); end
      #2;
      rst_n = 1'b0;
      #1;
      checks++; if (out_v !== 1'b0) begin errs++; $display("FAIL rmid_out_v: got %b exp 0", out_v); end
      checks++; if (out_data !== 16'h0000) begin errs++; $display("FAIL rmid_out_data: got %h exp 0000", out_data); end
      checks++; if (ovf !== 1'b0) begin errs++; $display("FAIL rmid_ovf: got %b exp 0", ovf); end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      out_rdy = 1'b1;
      n = 0;
      for (int cyc = 0; cyc < 30; cyc++) begin
         if ((cyc % 2 == 0) && (cyc / 2 < 8)) begin
            in_v    = 1'b1;
            in_data = (cyc == 0) ? 32'h1234_5678 : {16'(16'h2000 + cyc), 16'(16'h2000 + cyc + 1)};
         end else begin
            in_v = 1'b0;
         end
         if (out_v === 1'b1) begin
            if (n < 16) begin
               exp_l = (n == 15);
               checks++; if (out_data !== exp_seq[n]) begin errs++; $display("FAIL rmid_data[%0d]: got %h exp %h", n, out_data, exp_seq[n]); end
               checks++; if (out_last !== exp_l) begin errs++; $display("FAIL rmid_last[%0d]: got %b exp %b", n, out_last, exp_l); end
            end
            n++;
         end
         @(negedge clk);
      end
      in_v = 1'b0;
      checks++; if (n != 16) begin errs++; $display("FAIL rmid_count: got %0d exp 16", n); end
   endtask

   task automatic test_stream_model();
      logic [15:0] q[$];
      logic [15:0] exp_d;
      logic [31:0] w;
      logic exp_l;
      int nwords;
      int n;
      do_reset();
      nwords = 0;
      n = 0;
      for (int cyc = 0; cyc < 160; cyc++) begin
         out_rdy = (cyc % 3 != 2);
         if ((cyc % 4 == 0) && (nwords < 12)) begin
            w       = $urandom;
            in_v    = 1'b1;
            in_data = w;
            q.push_back(w[31:16]);
            q.push_back(w[15:0]);
            nwords++;
         end else begin
            in_v = 1'b0;
         end
         if (out_v === 1'b1 && out_rdy === 1'b1) begin
            if (q.size() == 0) begin
               checks++; errs++; $display("FAIL model_extra[%0d]: got element %h exp none", n, out_data);
            end else begin
               exp_d = q.pop_front();
               exp_l = ((n % 16) == 15);
               checks++; if (out_data !== exp_d) begin errs++; $display("FAIL model_data[%0d]: got %h exp %h", n, out_data, exp_d); end
               checks++; if (out_last !== exp_l) begin errs++; $display("FAIL model_last[%0d]: got %b exp %b", n, out_last, exp_l); end
            end
            n++;
         end
         @(negedge clk);
      end
      in_v = 1'b0;
      checks++; if (n != 24) begin errs++; $display("FAIL model_count: got %0d exp 24", n); end
      checks++; if (ovf !== 1'b0) begin errs++; $display("FAIL model_ovf: got %b exp 0", ovf); end
      checks++; if (out_v !== 1'b0) begin errs++; $display("FAIL model_idle: got %b exp 0", out_v); end
   endtask

   initial begin
      errs    = 0;
      checks  = 0;
      rst_n   = 1'b0;
      in_v    = 1'b0;
      in_data = '0;
      out_rdy = 1'b0;
      test_reset();
      test_single_word();
      test_pixel_framing();
      test_backpressure();
      test_overflow();
      test_full_pop();
      test_reset_mid();
      test_stream_model();
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
